// File: rtl/printer_pkg.sv
// Shared types and defaults for the Oric Centronics printer receiver.
// PRINTER_FLOW_CTRL_EN adds the FULL_WAIT state (stall instead of drop when the FIFO is full).
package printer_pkg;

  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_ACK_CYCLES = 48;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PUSH      = 3'd1,
    S_WAIT_HIGH = 3'd2,
    S_ACK       = 3'd3
`ifdef PRINTER_FLOW_CTRL_EN
    ,
    S_FULL_WAIT = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/printer_fifo.sv
// First-word-fall-through byte FIFO; push when full and pop when empty are ignored.
module printer_fifo
  import printer_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int FW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  byte_t         i_wdata,
  input  logic          i_pop,
  output byte_t         o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [FW-1:0] o_fill
);

  localparam int AW = $clog2(DEPTH);

  byte_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [FW-1:0] r_count;
  logic          w_push_en;
  logic          w_pop_en;

  // Full comes from the registered count, so a same-cycle pop never frees a slot for a push.
  assign o_full    = (r_count == FW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_fill    = r_count;
  assign w_push_en = i_push && !o_full;
  assign w_pop_en  = i_pop && !o_empty;
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push_en) r_mem[r_wr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_en) r_wr <= r_wr + AW'(1);
      if (w_pop_en)  r_rd <= r_rd + AW'(1);
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + FW'(1);
        2'b01:   r_count <= r_count - FW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/printer_port.sv
// Centronics printer receiver on the VIA port: sync strobe/data, queue bytes, pulse ACK.
// Define PRINTER_FLOW_CTRL_EN to hold BUSY and stall instead of dropping bytes when full.
module printer_port
  import printer_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ACK_CYCLES = DEF_ACK_CYCLES
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic [7:0]                    via_pa_out,
  input  logic                          via_strobe,
  output logic                          printer_ack,
  output logic                          printer_busy,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(ACK_CYCLES) + 1;
  localparam logic [CW-1:0] ACK_LOAD = CW'(ACK_CYCLES - 1);

  logic          r_stb_s1, r_stb_s2, r_stb_s3;
  byte_t         r_dat_s1, r_dat_s2, r_latch;
  logic          r_pending, r_overflow;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          w_fall, w_take, w_push, w_drop, w_load;
  logic          w_full, w_empty;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_stb_s1 <= 1'b1;
      r_stb_s2 <= 1'b1;
      r_stb_s3 <= 1'b1;
      r_dat_s1 <= '0;
      r_dat_s2 <= '0;
    end else begin
      r_stb_s1 <= via_strobe;
      r_stb_s2 <= r_stb_s1;
      r_stb_s3 <= r_stb_s2;
      r_dat_s1 <= via_pa_out;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall = r_stb_s3 && !r_stb_s2;
  // An edge seen in IDLE is serviced directly; pending only matters while busy.
  assign w_take = (r_state == S_IDLE) && (r_pending || w_fall);

  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    w_drop = 1'b0;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: if (w_take) w_next = S_PUSH;
      S_PUSH: begin
        if (!w_full) begin
          w_push = 1'b1;
          w_next = S_WAIT_HIGH;
        end else begin
`ifdef PRINTER_FLOW_CTRL_EN
          w_next = S_FULL_WAIT;
`else
          w_drop = 1'b1;
          w_next = S_WAIT_HIGH;
`endif
        end
      end
      S_WAIT_HIGH: begin
        if (r_stb_s2) begin
          w_next = S_ACK;
          w_load = 1'b1;
        end
      end
      S_ACK: if (r_cnt == '0) w_next = S_IDLE;
`ifdef PRINTER_FLOW_CTRL_EN
      S_FULL_WAIT: begin
        if (!w_full) begin
          w_push = 1'b1;
          if (r_stb_s2) begin
            w_next = S_ACK;
            w_load = 1'b1;
          end else begin
            w_next = S_WAIT_HIGH;
          end
        end
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pending  <= 1'b0;
      r_overflow <= 1'b0;
      r_latch    <= '0;
    end else begin
      r_state <= w_next;
      if (w_load)                            r_cnt <= ACK_LOAD;
      else if (r_state == S_ACK && r_cnt != '0) r_cnt <= r_cnt - CW'(1);
      if (w_take)      r_pending <= 1'b0;
      else if (w_fall) r_pending <= 1'b1;
      // Byte is captured at the strobe edge so a short strobe cannot pick up later data.
      if (w_fall && !r_pending) r_latch <= r_dat_s2;
      if (w_drop || (w_fall && r_pending)) r_overflow <= 1'b1;
    end
  end

  printer_fifo #(.DEPTH(FIFO_DEPTH), .FW(FW)) u_fifo (
    .clk     (clk_sys),
    .rst     (reset),
    .i_push  (w_push),
    .i_wdata (r_latch),
    .i_pop   (out_ready),
    .o_rdata (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_fill  (fill)
  );

  assign out_valid    = !w_empty;
  assign printer_ack  = (r_state != S_ACK);
  assign printer_busy = (r_state != S_IDLE) || w_full;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_printer_port.sv
// Directed bench for printer_port; build with PRINTER_FLOW_CTRL_EN to exercise the stall variant.
module tb_printer_port;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] via_pa_out = 8'h00;
  logic       via_strobe = 1'b1;
  logic       printer_ack, printer_busy;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       overflow;
  logic [4:0] fill;

  int errors = 0;
  int checks = 0;
  int n_ack  = 0;

  printer_port dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .via_pa_out   (via_pa_out),
    .via_strobe   (via_strobe),
    .printer_ack  (printer_ack),
    .printer_busy (printer_busy),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow),
    .fill         (fill)
  );

  always #5 clk_sys = ~clk_sys;
  always @(negedge printer_ack) n_ack++;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; via_strobe = 1'b1; out_ready = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  // Waits for one complete ACK pulse, bounded.
  task automatic wait_ack(output bit ok);
    int n;
    ok = 1'b0; n = 0;
    while (printer_ack !== 1'b0 && n < 400) begin tick(1); n++; end
    if (printer_ack === 1'b0) begin
      n = 0;
      while (printer_ack !== 1'b1 && n < 400) begin tick(1); n++; end
      ok = (printer_ack === 1'b1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int low);
    bit ok;
    via_pa_out = b; via_strobe = 1'b0;
    tick(low);
    via_strobe = 1'b1;
    wait_ack(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL send_ack_%02h: ack pulse not seen, required one", b); end
    tick(2);
  endtask

  task automatic drain(input string name, input logic [7:0] first, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== first + 8'(i)) begin
        errors++;
        $display("FAIL %s_%0d: valid=%b data=%02h, required valid=1 data=%02h", name, i, out_valid, out_data, first + 8'(i));
      end
      out_ready = 1'b1; tick(1); out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    checks++;
    if ({printer_ack, printer_busy, out_valid, overflow} !== 4'b1000 || out_data !== 8'h00 || fill !== 5'd0) begin
      errors++;
      $display("FAIL reset_values: ack=%b busy=%b valid=%b ovf=%b data=%02h fill=%0d, required 1 0 0 0 00 0",
               printer_ack, printer_busy, out_valid, overflow, out_data, fill);
    end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_single_byte();
    do_reset();
    via_pa_out = 8'h41; via_strobe = 1'b0;
    tick(3);
    checks++;
    if (out_valid !== 1'b0 || printer_busy !== 1'b1) begin
      errors++; $display("FAIL single_cycle3: valid=%b busy=%b, required 0 1", out_valid, printer_busy);
    end
    tick(1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h41 || fill !== 5'd1) begin
      errors++; $display("FAIL single_cycle4: valid=%b data=%02h fill=%0d, required 1 41 1", out_valid, out_data, fill);
    end
    tick(6);
    via_strobe = 1'b1;
    tick(2);
    checks++;
    if (printer_ack !== 1'b1) begin errors++; $display("FAIL single_ack_n2: ack=%b, required 1", printer_ack); end
    tick(1);
    checks++;
    if (printer_ack !== 1'b0) begin errors++; $display("FAIL single_ack_n3: ack=%b, required 0", printer_ack); end
    tick(47);
    checks++;
    if (printer_ack !== 1'b0) begin errors++; $display("FAIL single_ack_last: ack=%b, required 0", printer_ack); end
    tick(1);
    checks++;
    if (printer_ack !== 1'b1 || printer_busy !== 1'b0) begin
      errors++; $display("FAIL single_ack_end: ack=%b busy=%b, required 1 0", printer_ack, printer_busy);
    end
  endtask

`ifdef PRINTER_FLOW_CTRL_EN
  task automatic test_burst();
    int a0;
    bit ok;
    do_reset();
    a0 = n_ack;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 4);
    via_pa_out = 8'h10; via_strobe = 1'b0;
    tick(4);
    via_strobe = 1'b1;
    tick(80);
    checks++;
    if (n_ack - a0 !== 16 || printer_busy !== 1'b1 || fill !== 5'd16) begin
      errors++; $display("FAIL burst_stall: acks=%0d busy=%b fill=%0d, required 16 1 16", n_ack - a0, printer_busy, fill);
    end
    drain("burst_head", 8'h00, 1);
    wait_ack(ok);
    checks++;
    if (!ok || fill !== 5'd16) begin
      errors++; $display("FAIL burst_resume: ack_seen=%b fill=%0d, required 1 16", ok, fill);
    end
    drain("burst_order", 8'h01, 16);
    for (int i = 17; i < 20; i++) send_byte(8'(i), 4);
    drain("burst_tail", 8'h11, 3);
    checks++;
    if (overflow !== 1'b0 || n_ack - a0 !== 20) begin
      errors++; $display("FAIL burst_summary: ovf=%b acks=%0d, required 0 20", overflow, n_ack - a0);
    end
  endtask
`else
  task automatic test_burst();
    int a0;
    do_reset();
    a0 = n_ack;
    for (int i = 0; i < 20; i++) send_byte(8'(i), 4);
    checks++;
    if (n_ack - a0 !== 20 || fill !== 5'd16 || overflow !== 1'b1) begin
      errors++; $display("FAIL burst_drop: acks=%0d fill=%0d ovf=%b, required 20 16 1", n_ack - a0, fill, overflow);
    end
    drain("burst_order", 8'h00, 16);
    checks++;
    if (out_valid !== 1'b0 || fill !== 5'd0) begin
      errors++; $display("FAIL burst_empty: valid=%b fill=%0d, required 0 0", out_valid, fill);
    end
  endtask
`endif

  task automatic test_pending();
    int a0, n;
    bit ok1, ok2;
    do_reset();
    a0 = n_ack;
    via_pa_out = 8'h55; via_strobe = 1'b0;
    tick(4);
    via_strobe = 1'b1;
    n = 0;
    while (printer_ack !== 1'b0 && n < 50) begin tick(1); n++; end
    tick(5);
    via_pa_out = 8'h66; via_strobe = 1'b0;
    tick(3);
    via_strobe = 1'b1;
    wait_ack(ok1);
    wait_ack(ok2);
    checks++;
    if (!ok1 || !ok2 || n_ack - a0 !== 2 || fill !== 5'd2 || overflow !== 1'b0) begin
      errors++; $display("FAIL pending: acks=%0d fill=%0d ovf=%b, required 2 2 0", n_ack - a0, fill, overflow);
    end
    drain("pending_first", 8'h55, 1);
    drain("pending_second", 8'h66, 1);
  endtask

  task automatic test_reset_mid_ack();
    int n;
    do_reset();
    send_byte(8'h11, 4);
    send_byte(8'h22, 4);
    via_pa_out = 8'h33; via_strobe = 1'b0;
    tick(4);
    via_strobe = 1'b1;
    n = 0;
    while (printer_ack !== 1'b0 && n < 50) begin tick(1); n++; end
    tick(5);
    checks++;
    if (printer_ack !== 1'b0 || fill !== 5'd3) begin
      errors++; $display("FAIL rst_pre: ack=%b fill=%0d, required 0 3", printer_ack, fill);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (printer_ack !== 1'b1 || fill !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || printer_busy !== 1'b0) begin
      errors++; $display("FAIL rst_async: ack=%b fill=%0d valid=%b ovf=%b busy=%b, required 1 0 0 0 0",
                         printer_ack, fill, out_valid, overflow, printer_busy);
    end
    tick(2);
    reset = 1'b0;
    tick(1);
    send_byte(8'h77, 4);
    checks++;
    if (fill !== 5'd1 || out_data !== 8'h77) begin
      errors++; $display("FAIL rst_after: fill=%0d data=%02h, required 1 77", fill, out_data);
    end
  endtask

  task automatic test_push_pop();
    bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 4);
    checks++;
    if (fill !== 5'd5) begin errors++; $display("FAIL pp_fill5: fill=%0d, required 5", fill); end
    via_pa_out = 8'hA5; via_strobe = 1'b0;
    tick(3);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    checks++;
    if (fill !== 5'd5 || out_data !== 8'hA1) begin
      errors++; $display("FAIL pp_simul: fill=%0d head=%02h, required 5 a1", fill, out_data);
    end
    tick(1);
    via_strobe = 1'b1;
    wait_ack(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pp_ack: ack pulse not seen, required one"); end
    drain("pp_order", 8'hA1, 5);
  endtask

  task automatic test_short_strobe();
    int a0;
    bit ok;
    do_reset();
    a0 = n_ack;
    via_pa_out = 8'h3C; via_strobe = 1'b0;
    tick(1);
    via_strobe = 1'b1;
    tick(1);
    via_pa_out = 8'hFF;
    wait_ack(ok);
    checks++;
    if (!ok || fill !== 5'd1 || out_data !== 8'h3C) begin
      errors++; $display("FAIL short_capture: ack_seen=%b fill=%0d data=%02h, required 1 1 3c", ok, fill, out_data);
    end
    tick(20);
    checks++;
    if (fill !== 5'd1 || n_ack - a0 !== 1) begin
      errors++; $display("FAIL short_spurious: fill=%0d acks=%0d, required 1 1", fill, n_ack - a0);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_pending();
    test_reset_mid_ack();
    test_push_pop();
    test_short_strobe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/printer_port.md
# printer_port

Centronics-style printer receiver for the Oric's VIA parallel port: the device that sits at the far end of the port A data lines and the active-low printer strobe that the Oric ROM drives when printing. Each strobed byte is captured, queued in a small FIFO toward the host side (HPS/file sink), and acknowledged with a timed active-low ACK pulse back to the VIA CA1 input, with BUSY reflecting the receiver's readiness.

## Interface
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥2
- ACK_CYCLES, 48, ACK low-pulse width in clk_sys cycles, ≥1
- clk_sys  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high reset
- via_pa_out  in  8  printer data driven by VIA port A
- via_strobe  in  1  printer strobe, active low, asynchronous to clk_sys
- printer_ack  out  1  ACK to VIA CA1, active low
- printer_busy  out  1  BUSY, active high
- out_data  out  8  FIFO head byte, valid while out_valid
- out_valid  out  1  FIFO not empty
- out_ready  in  1  host consumes head when out_valid && out_ready
- overflow  out  1  sticky: a byte was dropped; cleared only by reset
- fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- via_strobe and via_pa_out pass through identical 2-flop synchronizer chains, keeping data aligned with strobe; strobe low must last ≥2 clk_sys cycles.
- Falling edge of synchronized strobe sets a `pending` flag; flag clears when the FSM leaves IDLE to service it.
- FSM states: IDLE, PUSH, WAIT_HIGH, ACK, FULL_WAIT (FULL_WAIT present only with the macro).
- IDLE: pending -> PUSH.
- PUSH (1 cycle): FIFO not full -> write synchronized data, go WAIT_HIGH. FIFO full -> see Configuration.
- WAIT_HIGH: synchronized strobe high -> ACK, load counter with ACK_CYCLES-1.
- ACK: printer_ack low; counter decrements; at 0 -> IDLE.
- A strobe falling edge occurring in any non-IDLE state sets pending and is serviced on return to IDLE; a second edge while pending is already set sets overflow.
- printer_busy = (state != IDLE) || FIFO full.
- FIFO is first-word-fall-through: out_data = head whenever out_valid. Simultaneous push and pop with 0 < fill < FIFO_DEPTH leaves fill unchanged. Full is evaluated from the registered count; a pop in the same cycle does not admit a push.
- Pointers wrap modulo FIFO_DEPTH; fill saturates never — push when full and pop when empty are suppressed.

## Timing
- Reset values: printer_ack=1, printer_busy=0, out_valid=0, out_data=0, overflow=0, fill=0, state=IDLE, pending=0, synchronizers=1 (strobe) / 0 (data).
- Strobe fall at pin in cycle 0 -> edge detected cycle 2 -> PUSH cycle 3 -> out_valid=1 and fill incremented cycle 4.
- Strobe rise at pin in cycle N (during WAIT_HIGH) -> ACK state entered, printer_ack low from cycle N+3 for exactly ACK_CYCLES cycles.
- Reset asserted mid-transfer: all state returns to reset values immediately; FIFO contents discarded; ACK pulse aborted (ack high).

## Configuration
- PRINTER_FLOW_CTRL_EN defined: PUSH with FIFO full -> FULL_WAIT; busy held high, no ACK; when not full -> write byte, -> WAIT_HIGH (or ACK directly if strobe already high). No byte loss; overflow set only by the double-pending case.
- Not defined: PUSH with FIFO full drops the byte, sets overflow, continues to WAIT_HIGH and ACKs normally (printer never stalls the Oric).

## Structure
- Package printer_pkg: state enum type, default ACK_CYCLES and FIFO_DEPTH constants, data byte typedef.
- One sub-module: printer_fifo (parameterized FWFT FIFO, push/pop/full/empty/fill). Synchronizers, edge detect, FSM and ACK counter live in printer_port.

## Test plan
- Single byte: data 0x41, strobe low 10 cycles -> out_data=0x41, out_valid at cycle 4, printer_ack low exactly 48 cycles after strobe rise +3, busy low afterward.
- Burst of 20 bytes 0x00..0x13 with out_ready=0, macro off -> fill=16, bytes 0x00..0x0F retained in order, overflow=1, 20 ACK pulses.
- Same burst, macro on -> after 16th byte busy stays high, no ACK for byte 17 until out_ready pulsed once; then all 20 bytes delivered in order, overflow=0.
- Second strobe falling during ACK of byte 0x55 with data 0x66 -> 0x66 captured after ACK ends, two ACK pulses, overflow=0.
- Reset asserted mid-ACK with fill=3 -> printer_ack=1, fill=0, out_valid=0, overflow=0 same cycle; next strobe handled normally.
- Simultaneous push and pop at fill=5 -> fill stays 5, order preserved; strobe of 1 cycle width tolerated without spurious capture of stale data.
